// File: rtl/ddr_frame_arbiter_if.sv
// ddr_frame_arbiter_if: DDR user command port between the frame arbiter and the controller
interface ddr_frame_arbiter_if #(parameter int ADDR_W = 24);
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic burst_done;
  modport master(output cmd_valid, cmd_write, cmd_addr, input cmd_ready, burst_done);
  modport slave(input cmd_valid, cmd_write, cmd_addr, output cmd_ready, burst_done);
endinterface

// File: rtl/ddr_frame_arbiter.sv
// ddr_frame_arbiter: camera-write / LCD-read DDR burst scheduler over a triple-buffered frame store
module ddr_frame_arbiter #(
  parameter int BURST_LEN   = 64,
  parameter int FRAME_WORDS = 65280,
  parameter int BANK_STRIDE = 'h20000,
  parameter int ADDR_W      = 24,
  parameter int FIFO_AW     = 9
) (
  input  logic               ddr_clk,
  input  logic               ddr_rst_n,
  input  logic               ddr_init_done,
  input  logic               cam_vsync,
  input  logic               lcd_framesync,
  input  logic [FIFO_AW-1:0] wr_usedw,
  input  logic [FIFO_AW-1:0] rd_usedw,
  ddr_frame_arbiter_if.master cmd,
  output logic               wr_frame_full,
  output logic [1:0]         rd_bank_o
);
  typedef enum logic [1:0] {INIT, ARB, CMD, WAIT} state_t;
  state_t state, state_n;
  logic [2:0] cam_s, lcd_s;
  logic cam_eof, lcd_sof, cam_pend, lcd_pend, last_grant;
  logic [1:0] wr_bank, rd_bank, ready_bank, wr_bank_a, rd_bank_a, ready_bank_a;
  logic [16:0] wr_ptr, rd_ptr, wr_ptr_a, rd_ptr_a, rd_ptr_inc;
  logic apply, full_a, wr_req, rd_req, rd_urgent, grant, grant_w, accept;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] b, input logic [16:0] p);
    return ADDR_W'(32'(b) * 32'(BANK_STRIDE) + 32'(p));
  endfunction

  assign cam_eof       = cam_s[1] & ~cam_s[2];
  assign lcd_sof       = ~lcd_s[1] & lcd_s[2];
  assign apply         = (state == ARB) && ddr_init_done;
  assign cmd.cmd_valid = (state == CMD) && ddr_init_done;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign wr_frame_full = wr_ptr == 17'(FRAME_WORDS);
  assign rd_bank_o     = rd_bank;
  assign rd_ptr_inc    = rd_ptr + 17'(BURST_LEN);

  // Frame events are resolved first so the grant below already sees the swapped banks/pointers
  always_comb begin
    wr_bank_a    = wr_bank;
    ready_bank_a = ready_bank;
    wr_ptr_a     = wr_ptr;
    rd_bank_a    = rd_bank;
    rd_ptr_a     = rd_ptr;
    if (apply && cam_pend) begin
      if (wr_frame_full) begin
        ready_bank_a = wr_bank;
        wr_bank_a    = 2'd3 - rd_bank - wr_bank;
      end
      wr_ptr_a = '0;
    end
    if (apply && lcd_pend) begin
      rd_bank_a = ready_bank_a;
      rd_ptr_a  = '0;
    end
    full_a    = wr_ptr_a == 17'(FRAME_WORDS);
    wr_req    = 32'(wr_usedw) >= 32'(BURST_LEN) && !full_a;
    rd_req    = 32'(rd_usedw) <= 32'((1 << FIFO_AW) - BURST_LEN);
    rd_urgent = 32'(rd_usedw) < 32'(BURST_LEN);
    grant     = wr_req || rd_req;
    grant_w   = !rd_urgent && wr_req && (!rd_req || !last_grant);
  end

  always_comb begin
    state_n = state;
    case (state)
      INIT:    state_n = ARB;
      ARB:     state_n = grant ? CMD : ARB;
      CMD:     state_n = cmd.cmd_ready ? WAIT : CMD;
      default: state_n = cmd.burst_done ? ARB : WAIT;
    endcase
    if (!ddr_init_done) state_n = INIT;
  end

  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      state        <= INIT;
      cam_s        <= '0;
      lcd_s        <= '0;
      cam_pend     <= 1'b0;
      lcd_pend     <= 1'b0;
      wr_bank      <= 2'd0;
      ready_bank   <= 2'd2;
      rd_bank      <= 2'd2;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      last_grant   <= 1'b1;
      cmd.cmd_write <= 1'b0;
      cmd.cmd_addr  <= '0;
    end else begin
      state      <= state_n;
      cam_s      <= {cam_s[1:0], cam_vsync};
      lcd_s      <= {lcd_s[1:0], lcd_framesync};
      cam_pend   <= cam_eof | (cam_pend & ~apply);
      lcd_pend   <= lcd_sof | (lcd_pend & ~apply);
      wr_bank    <= wr_bank_a;
      ready_bank <= ready_bank_a;
      rd_bank    <= rd_bank_a;
      wr_ptr     <= (accept && cmd.cmd_write) ? wr_ptr + 17'(BURST_LEN) : wr_ptr_a;
      rd_ptr     <= (accept && !cmd.cmd_write) ? (rd_ptr_inc == 17'(FRAME_WORDS) ? '0 : rd_ptr_inc) : rd_ptr_a;
      if (accept) last_grant <= cmd.cmd_write;
      if (apply && grant) begin
        cmd.cmd_write <= grant_w;
        cmd.cmd_addr  <= grant_w ? addr_of(wr_bank_a, wr_ptr_a) : addr_of(rd_bank_a, rd_ptr_a);
      end
    end
  end
endmodule
